datapath_core: RTL
==================

# datapath_core

Parametrised successor to the 16-bit bus datapath. It holds the ALU with its operand and result latches, the program counter, a register file of NUM_REGS entries, MAR/MDR with a handshaked memory controller, and NUM_PORTS I/O ports. All of these share one internal bus, selected by one-hot source enables. The block sits between the control unit, which drives every enable, and the external memory.

## Interface
- DATA_W, 16, bus, register, ALU and port width
- ADDR_W, 16, PC/MAR width; must be ≤ DATA_W
- NUM_REGS, 4, general-purpose registers, 1..16
- NUM_PORTS, 2, I/O ports, 1..8
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- src_en  in  NUM_REGS+NUM_PORTS+4  one-hot bus source select. Bits: 0 ALU result, 1 PC, 2 MDR-read, 3 ext_in, 4.. regs, then ports
- dst_latch  in  NUM_REGS+NUM_PORTS+4  bus destination latch enables. Bits: 0 ALU A, 1 ALU B, 2 MAR, 3 MDR-write, 4.. regs, then port outputs
- ext_in  in  DATA_W  external bus injection (test/boot)
- alu_op  in  3  ALU function
- alu_out_latch  in  1  capture ALU result
- pc_inc, pc_load  in  1 each  PC increment / load from bus
- mem_start, mem_rd  in  1 each  start memory cycle; 1 = read, 0 = write
- mem_busy, mem_done  out  1 each  cycle in progress / one-cycle completion pulse
- mem_en, mem_we  out  1 each  memory request / write strobe
- mem_addr  out  ADDR_W  from MAR
- mem_wdata  out  DATA_W  from MDR-write
- mem_rdata  in  DATA_W  read data
- mem_mfc  in  1  memory function complete
- port_in  in  NUM_PORTS*DATA_W  port inputs, port i at [i*DATA_W +: DATA_W]
- port_out  out  NUM_PORTS*DATA_W  port output registers
- bus  out  DATA_W  current bus value (observability)
- bus_err  out  1  sticky contention flag (0 when feature compiled out)

## Operation
- **Bus:** AND-OR of enabled sources. 0 when no source is enabled.
- **Destinations:** every destination whose dst_latch bit is set captures the bus at the edge. Broadcast to several destinations is legal.
- **Register as both source and destination:** the register keeps its value.
- **MAR:** takes bus[ADDR_W-1:0].
- **ALU:** combinational on the A/B latches. Result latched by alu_out_latch.
  - 000 A+B; 001 A−B; 010 A&B; 011 A|B; 100 A^B; 101 ~A; 110 A<<1; 111 A.
  - All results truncated to DATA_W; no flags.
- **PC:**
  - pc_load beats pc_inc when both are asserted.
  - Increment wraps from 2^ADDR_W−1 to 0.
- **Port inputs:** sampled into a port-input register every cycle. The port source drives that registered value.
- **Memory controller FSM:**
  - IDLE: mem_start → REQ. Captures mem_rd. mem_busy=1.
  - REQ: mem_en=1, mem_we=!rd. On mem_mfc=1: for a read, MDR-read ← mem_rdata; → DONE.
  - DONE: mem_en=0, mem_done=1 for one cycle → IDLE.
  - mem_start outside IDLE is ignored.
  - MAR and MDR-write may change during REQ; the memory sees the live values.
- **Reset (any time, including mid-cycle):**
  - All registers, PC, ALU latches, MAR, MDRs and port registers go to 0.
  - FSM goes to IDLE; mem_en, mem_we, mem_busy, mem_done, bus_err go to 0.

## Timing
- Bus-to-register transfer: 1 cycle. Source enabled in cycle n, destination valid after edge n.
- ALU: operands latched at edge n, alu_out_latch in cycle n+1, result on bus from cycle n+2.
- Memory:
  - mem_start at edge n → mem_en high from n+1.
  - mem_mfc sampled high at edge m → mem_en low and mem_done high for cycle m+1.
  - Read data is on the bus (via MDR-read) from cycle m+1.
  - Minimum total: 3 cycles from mem_start to mem_done.
- port_in to bus: 1 cycle of latency.

## Configuration
- **BUS_CONTENTION_CHK_EN defined:**
  - More than one src_en bit set → bus forced to 0 that cycle.
  - bus_err set at the following edge and held until reset.
- **Not defined:**
  - Multiple sources are ORed.
  - bus_err tied to 0.

## Structure
- Shared package dp_pkg holds:
  - ALU opcode constants.
  - Fixed source/destination bit offsets (SRC_ALU, SRC_PC, SRC_MDR, SRC_EXT, SRC_REG0; DST_A, DST_B, DST_MAR, DST_MDR, DST_REG0).
  - Memory FSM state typedef (IDLE/REQ/DONE).
- One sub-module, dp_mem_ctrl: memory FSM plus the MDR-read capture.

## Test plan
- Reset with ext_in=16'hBEEF and regs preloaded → every output and register reads 0, bus_err=0.
- ext_in=5 → A, ext_in=3 → B, alu_op=001, latch, ALU result → r2 → r2 = 2. Repeat with A=0, B=1 → 16'hFFFF (wrap).
- PC = 16'hFFFF via pc_load, then pc_inc → PC = 0. pc_load and pc_inc together with bus=16'h0040 → PC = 16'h0040.
- MAR=16'h0010, mem_start with mem_rd=1, mem_mfc delayed 4 cycles, mem_rdata=16'h1234 → mem_en high 4 cycles, mem_done pulses once, MDR source gives 16'h1234. A second mem_start during busy is ignored.
- Reset asserted in REQ → mem_en=0 immediately (async), FSM returns to IDLE, no mem_done pulse.
- BUS_CONTENTION_CHK_EN defined, src_en with bits 1 and 4 set → bus=0, bus_err=1 and stays 1 after a legal select.

Source files
------------

// File: rtl/dp_pkg.sv
// Shared definitions for the bus datapath: ALU opcodes, fixed bus source and
// destination bit offsets, and the memory controller state encoding.
package dp_pkg;

   localparam logic [2:0] ALU_ADD  = 3'b000;
   localparam logic [2:0] ALU_SUB  = 3'b001;
   localparam logic [2:0] ALU_AND  = 3'b010;
   localparam logic [2:0] ALU_OR   = 3'b011;
   localparam logic [2:0] ALU_XOR  = 3'b100;
   localparam logic [2:0] ALU_NOT  = 3'b101;
   localparam logic [2:0] ALU_SHL  = 3'b110;
   localparam logic [2:0] ALU_PASS = 3'b111;

   // Registers follow REG0; ports follow the last register.
   localparam int SRC_ALU  = 0;
   localparam int SRC_PC   = 1;
   localparam int SRC_MDR  = 2;
   localparam int SRC_EXT  = 3;
   localparam int SRC_REG0 = 4;

   localparam int DST_A    = 0;
   localparam int DST_B    = 1;
   localparam int DST_MAR  = 2;
   localparam int DST_MDR  = 3;
   localparam int DST_REG0 = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } mem_state_e;

endpackage

// File: rtl/dp_mem_ctrl.sv
// Memory handshake controller: IDLE/REQ/DONE sequencing and MDR-read capture.
//
// state | meaning
// IDLE  | waiting for start, request direction captured on start
// REQ   | mem_en asserted, waiting for mfc from memory
// DONE  | one-cycle completion pulse, then back to IDLE
module dp_mem_ctrl
   import dp_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              start_i,
   input  logic              rd_i,
   input  logic              mfc_i,
   input  logic [DATA_W-1:0] rdata_i,
   output logic              en_o,
   output logic              we_o,
   output logic              busy_o,
   output logic              done_o,
   output logic [DATA_W-1:0] mdr_o
);

   mem_state_e        state_q, state_d;
   logic              rd_q;
   logic [DATA_W-1:0] mdr_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_q  <= 1'b0;
         mdr_q <= '0;
      end else begin
         if (state_q == IDLE && start_i) rd_q <= rd_i;
         if (state_q == REQ && mfc_i && rd_q) mdr_q <= rdata_i;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start_i) state_d = REQ;
         REQ:     if (mfc_i) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      en_o   = 1'b0;
      we_o   = 1'b0;
      busy_o = 1'b0;
      done_o = 1'b0;
      unique case (state_q)
         REQ: begin
            en_o   = 1'b1;
            we_o   = !rd_q;
            busy_o = 1'b1;
         end
         DONE: begin
            busy_o = 1'b1;
            done_o = 1'b1;
         end
         default: ;
      endcase
   end

   assign mdr_o = mdr_q;

endmodule

// File: rtl/datapath_core.sv
// Single-bus datapath: ALU, PC, register file, MAR/MDR with memory handshake,
// I/O ports. Define BUS_CONTENTION_CHK_EN to zero the bus and flag bus_err_o
// whenever more than one source is enabled.
module datapath_core
   import dp_pkg::*;
#(
   parameter int DATA_W    = 16,
   parameter int ADDR_W    = 16,
   parameter int NUM_REGS  = 4,
   parameter int NUM_PORTS = 2
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic [NUM_REGS+NUM_PORTS+3:0] src_en_i,
   input  logic [NUM_REGS+NUM_PORTS+3:0] dst_latch_i,
   input  logic [DATA_W-1:0]             ext_in_i,
   input  logic [2:0]                    alu_op_i,
   input  logic                          alu_out_latch_i,
   input  logic                          pc_inc_i,
   input  logic                          pc_load_i,
   input  logic                          mem_start_i,
   input  logic                          mem_rd_i,
   output logic                          mem_busy_o,
   output logic                          mem_done_o,
   output logic                          mem_en_o,
   output logic                          mem_we_o,
   output logic [ADDR_W-1:0]             mem_addr_o,
   output logic [DATA_W-1:0]             mem_wdata_o,
   input  logic [DATA_W-1:0]             mem_rdata_i,
   input  logic                          mem_mfc_i,
   input  logic [NUM_PORTS*DATA_W-1:0]   port_in_i,
   output logic [NUM_PORTS*DATA_W-1:0]   port_out_o,
   output logic [DATA_W-1:0]             bus_o,
   output logic                          bus_err_o
);

   localparam int NSEL      = NUM_REGS + NUM_PORTS + 4;
   localparam int SRC_PORT0 = SRC_REG0 + NUM_REGS;
   localparam int DST_PORT0 = DST_REG0 + NUM_REGS;

   logic [DATA_W-1:0] regs_q     [NUM_REGS];
   logic [DATA_W-1:0] port_out_q [NUM_PORTS];
   logic [DATA_W-1:0] port_in_q  [NUM_PORTS];
   logic [DATA_W-1:0] src_val    [NSEL];
   logic [DATA_W-1:0] a_q, b_q, alu_res_q, alu_y;
   logic [DATA_W-1:0] mdr_wr_q, mdr_rd;
   logic [DATA_W-1:0] bus_or, bus;
   logic [ADDR_W-1:0] pc_q, mar_q;

   always_comb begin
      for (int i = 0; i < NSEL; i++) src_val[i] = '0;
      src_val[SRC_ALU] = alu_res_q;
      src_val[SRC_PC]  = DATA_W'(pc_q);
      src_val[SRC_MDR] = mdr_rd;
      src_val[SRC_EXT] = ext_in_i;
      for (int i = 0; i < NUM_REGS; i++)  src_val[SRC_REG0 + i]  = regs_q[i];
      for (int i = 0; i < NUM_PORTS; i++) src_val[SRC_PORT0 + i] = port_in_q[i];
   end

   always_comb begin
      bus_or = '0;
      for (int i = 0; i < NSEL; i++)
         if (src_en_i[i]) bus_or = bus_or | src_val[i];
   end

`ifdef BUS_CONTENTION_CHK_EN
   logic multi_src, bus_err_q;

   // x & (x-1) clears the lowest set bit; anything left means two or more sources.
   assign multi_src = (src_en_i & (src_en_i - NSEL'(1))) != '0;
   assign bus       = multi_src ? '0 : bus_or;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) bus_err_q <= 1'b0;
      else         bus_err_q <= bus_err_q | multi_src;
   end

   assign bus_err_o = bus_err_q;
`else
   assign bus       = bus_or;
   assign bus_err_o = 1'b0;
`endif

   always_comb begin
      unique case (alu_op_i)
         ALU_ADD:  alu_y = a_q + b_q;
         ALU_SUB:  alu_y = a_q - b_q;
         ALU_AND:  alu_y = a_q & b_q;
         ALU_OR:   alu_y = a_q | b_q;
         ALU_XOR:  alu_y = a_q ^ b_q;
         ALU_NOT:  alu_y = ~a_q;
         ALU_SHL:  alu_y = a_q << 1;
         default:  alu_y = a_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         a_q       <= '0;
         b_q       <= '0;
         alu_res_q <= '0;
         pc_q      <= '0;
         mar_q     <= '0;
         mdr_wr_q  <= '0;
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
         for (int i = 0; i < NUM_PORTS; i++) begin
            port_out_q[i] <= '0;
            port_in_q[i]  <= '0;
         end
      end else begin
         if (dst_latch_i[DST_A])   a_q      <= bus;
         if (dst_latch_i[DST_B])   b_q      <= bus;
         if (dst_latch_i[DST_MAR]) mar_q    <= bus[ADDR_W-1:0];
         if (dst_latch_i[DST_MDR]) mdr_wr_q <= bus;
         // A register driving the bus onto itself is left untouched.
         for (int i = 0; i < NUM_REGS; i++)
            if (dst_latch_i[DST_REG0 + i] && !src_en_i[SRC_REG0 + i]) regs_q[i] <= bus;
         for (int i = 0; i < NUM_PORTS; i++) begin
            if (dst_latch_i[DST_PORT0 + i]) port_out_q[i] <= bus;
            port_in_q[i] <= port_in_i[i*DATA_W +: DATA_W];
         end
         if (alu_out_latch_i) alu_res_q <= alu_y;
         if (pc_load_i)      pc_q <= bus[ADDR_W-1:0];
         else if (pc_inc_i)  pc_q <= pc_q + ADDR_W'(1);
      end
   end

   for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port_out
      assign port_out_o[g*DATA_W +: DATA_W] = port_out_q[g];
   end

   dp_mem_ctrl #(.DATA_W(DATA_W)) u_mem_ctrl (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .start_i (mem_start_i),
      .rd_i    (mem_rd_i),
      .mfc_i   (mem_mfc_i),
      .rdata_i (mem_rdata_i),
      .en_o    (mem_en_o),
      .we_o    (mem_we_o),
      .busy_o  (mem_busy_o),
      .done_o  (mem_done_o),
      .mdr_o   (mdr_rd)
   );

   assign mem_addr_o  = mar_q;
   assign mem_wdata_o = mdr_wr_q;
   assign bus_o       = bus;

endmodule
